// File: rtl/cyclotron_trace_pkg.sv
// Shared sizes and record types for the Cyclotron trace collector.
// A trace record is one committed instruction plus up to three register writebacks.
package cyclotron_trace_pkg;

  localparam int ARCH_LEN       = 32;
  localparam int NUM_WARPS      = 8;
  localparam int WARP_ID_BITS   = $clog2(NUM_WARPS);
  localparam int NUM_LANES      = 16;
  localparam int REG_BITS       = 8;
  localparam int WB_PORTS       = 2;
  localparam int FIFO_DEPTH     = 4;
  localparam int MAX_TRACE_REGS = 3;
  localparam int DATA_BITS      = NUM_LANES * ARCH_LEN;

  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_COLLECT = 2'd1,
    SLOT_DONE    = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic                 enable;
    logic [REG_BITS-1:0]  address;
    logic [DATA_BITS-1:0] data;
  } trace_reg_t;

  typedef struct packed {
    logic [ARCH_LEN-1:0]                 pc;
    logic [WARP_ID_BITS-1:0]             warpId;
    trace_reg_t [MAX_TRACE_REGS-1:0]     regs;
  } trace_rec_t;

endpackage

// File: rtl/cyclotron_trace_collector_if.sv
// Commit, writeback and trace bundles of the trace collector.
// master = core/difftest side, slave = the collector.
interface cyclotron_trace_collector_if;
  import cyclotron_trace_pkg::*;

  logic                      commit_valid;
  logic                      commit_ready;
  logic [ARCH_LEN-1:0]       commit_pc;
  logic [WARP_ID_BITS-1:0]   commit_warpId;
  logic [1:0]                commit_numRegs;

  logic [WB_PORTS-1:0]       wb_valid;
  logic [WARP_ID_BITS-1:0]   wb_warpId  [WB_PORTS];
  logic [REG_BITS-1:0]       wb_address [WB_PORTS];
  logic [DATA_BITS-1:0]      wb_data    [WB_PORTS];

  logic                      trace_ready;
  logic                      trace_valid;
  logic [ARCH_LEN-1:0]       trace_pc;
  logic [WARP_ID_BITS-1:0]   trace_warpId;
  logic                      trace_regs_0_enable;
  logic [REG_BITS-1:0]       trace_regs_0_address;
  logic [DATA_BITS-1:0]      trace_regs_0_data;
  logic                      trace_regs_1_enable;
  logic [REG_BITS-1:0]       trace_regs_1_address;
  logic [DATA_BITS-1:0]      trace_regs_1_data;
  logic                      trace_regs_2_enable;
  logic [REG_BITS-1:0]       trace_regs_2_address;
  logic [DATA_BITS-1:0]      trace_regs_2_data;

  logic                      error;

  modport master (
    output commit_valid, commit_pc, commit_warpId, commit_numRegs,
    output wb_valid, wb_warpId, wb_address, wb_data, trace_ready,
    input  commit_ready, trace_valid, trace_pc, trace_warpId,
    input  trace_regs_0_enable, trace_regs_0_address, trace_regs_0_data,
    input  trace_regs_1_enable, trace_regs_1_address, trace_regs_1_data,
    input  trace_regs_2_enable, trace_regs_2_address, trace_regs_2_data,
    input  error
  );

  modport slave (
    input  commit_valid, commit_pc, commit_warpId, commit_numRegs,
    input  wb_valid, wb_warpId, wb_address, wb_data, trace_ready,
    output commit_ready, trace_valid, trace_pc, trace_warpId,
    output trace_regs_0_enable, trace_regs_0_address, trace_regs_0_data,
    output trace_regs_1_enable, trace_regs_1_address, trace_regs_1_data,
    output trace_regs_2_enable, trace_regs_2_address, trace_regs_2_data,
    output error
  );

endinterface

// File: rtl/cyclotron_trace_fifo.sv
// Small record FIFO; push and pop may share an edge, also when full.
// Head is read straight from storage so the consumer sees it with no extra stage.
module cyclotron_trace_fifo #(
  parameter type rec_t = cyclotron_trace_pkg::trace_rec_t,
  parameter int  DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  rec_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/cyclotron_trace_collector.sv
// Gathers per-instruction writebacks into per-warp slots and emits finished
// trace records through a small FIFO to the Cyclotron difftest stage.
module cyclotron_trace_collector
  import cyclotron_trace_pkg::*;
#(
  parameter int TRACE_FIFO_DEPTH = FIFO_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset,
  cyclotron_trace_collector_if.slave  bus
);

  // state   | meaning
  // IDLE    | no instruction outstanding, commit can be accepted
  // COLLECT | commit seen, filling reg entries until count == numRegs
  // DONE    | record complete, waiting for the drain arbiter
  localparam logic [1:0] ST_IDLE    = SLOT_IDLE;
  localparam logic [1:0] ST_COLLECT = SLOT_COLLECT;
  localparam logic [1:0] ST_DONE    = SLOT_DONE;

  logic [1:0]              st_q   [NUM_WARPS];
  logic [1:0]              st_d   [NUM_WARPS];
  logic [1:0]              cnt_q  [NUM_WARPS];
  logic [1:0]              cnt_d  [NUM_WARPS];
  logic [1:0]              num_q  [NUM_WARPS];
  logic [1:0]              num_d  [NUM_WARPS];
  logic [ARCH_LEN-1:0]     pc_q   [NUM_WARPS];
  logic [ARCH_LEN-1:0]     pc_d   [NUM_WARPS];
  logic [REG_BITS-1:0]     addr_q [NUM_WARPS][MAX_TRACE_REGS];
  logic [REG_BITS-1:0]     addr_d [NUM_WARPS][MAX_TRACE_REGS];
  logic [DATA_BITS-1:0]    data_q [NUM_WARPS][MAX_TRACE_REGS];
  logic [DATA_BITS-1:0]    data_d [NUM_WARPS][MAX_TRACE_REGS];

  logic [WARP_ID_BITS-1:0] rr_q;
  logic [WARP_ID_BITS-1:0] win;
  logic                    win_found;
  logic                    commit_ready;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    err_set;
  logic                    error_q;
  trace_rec_t              push_rec;
  trace_rec_t              head_rec;

  assign commit_ready = (st_q[bus.commit_warpId] == ST_IDLE);
  assign pop          = !fifo_empty && bus.trace_ready;
  assign push         = win_found && (!fifo_full || pop);

  // Round-robin search starting at the pointer; warp count is a power of two so the index wraps.
  always_comb begin
    logic [WARP_ID_BITS-1:0] idx;
    idx       = '0;
    win       = rr_q;
    win_found = 1'b0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = rr_q + WARP_ID_BITS'(k);
      if (!win_found && st_q[idx] == ST_DONE) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    push_rec        = '0;
    push_rec.pc     = pc_q[win];
    push_rec.warpId = win;
    for (int i = 0; i < MAX_TRACE_REGS; i++) begin
      if (2'(i) < num_q[win]) begin
        push_rec.regs[i].enable  = 1'b1;
        push_rec.regs[i].address = addr_q[win][i];
        push_rec.regs[i].data    = data_q[win][i];
      end
    end
  end

  // Ports are walked low to high so same-warp hits land in consecutive entries.
  always_comb begin
    logic [WARP_ID_BITS-1:0] w;
    w       = '0;
    st_d    = st_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_set = 1'b0;

    for (int p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_valid[p]) begin
        w = bus.wb_warpId[p];
        if (st_d[w] == ST_COLLECT && cnt_d[w] < num_q[w]) begin
          for (int i = 0; i < MAX_TRACE_REGS; i++) begin
            if (cnt_d[w] == 2'(i)) begin
              addr_d[w][i] = bus.wb_address[p];
              data_d[w][i] = bus.wb_data[p];
            end
          end
          cnt_d[w] = cnt_d[w] + 2'd1;
          if (cnt_d[w] == num_q[w]) begin
            st_d[w] = ST_DONE;
          end
        end else begin
          err_set = 1'b1;
        end
      end
    end

    if (bus.commit_valid && commit_ready) begin
      w        = bus.commit_warpId;
      pc_d[w]  = bus.commit_pc;
      num_d[w] = bus.commit_numRegs;
      cnt_d[w] = 2'd0;
      st_d[w]  = (bus.commit_numRegs == 2'd0) ? ST_DONE : ST_COLLECT;
    end

    if (push) begin
      st_d[win] = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        st_q[w]  <= ST_IDLE;
        cnt_q[w] <= '0;
        num_q[w] <= '0;
        pc_q[w]  <= '0;
        for (int i = 0; i < MAX_TRACE_REGS; i++) begin
          addr_q[w][i] <= '0;
          data_q[w][i] <= '0;
        end
      end
      rr_q    <= '0;
      error_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_q | err_set;
      if (push) begin
        rr_q <= win + WARP_ID_BITS'(1);
      end
    end
  end

  cyclotron_trace_fifo #(
    .rec_t (trace_rec_t),
    .DEPTH (TRACE_FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.commit_ready         = commit_ready;
  assign bus.trace_valid          = !fifo_empty;
  assign bus.trace_pc             = head_rec.pc;
  assign bus.trace_warpId         = head_rec.warpId;
  assign bus.trace_regs_0_enable  = head_rec.regs[0].enable;
  assign bus.trace_regs_0_address = head_rec.regs[0].address;
  assign bus.trace_regs_0_data    = head_rec.regs[0].data;
  assign bus.trace_regs_1_enable  = head_rec.regs[1].enable;
  assign bus.trace_regs_1_address = head_rec.regs[1].address;
  assign bus.trace_regs_1_data    = head_rec.regs[1].data;
  assign bus.trace_regs_2_enable  = head_rec.regs[2].enable;
  assign bus.trace_regs_2_address = head_rec.regs[2].address;
  assign bus.trace_regs_2_data    = head_rec.regs[2].data;
  assign bus.error                = error_q;

endmodule

// File: tb/tb_cyclotron_trace_collector.sv
// Directed and randomized bench for cyclotron_trace_collector against a
// record-level model (per-warp pending writes, completion pointer, record queue).
module tb_cyclotron_trace_collector;
  import cyclotron_trace_pkg::*;

  localparam int M_IDLE = 0, M_COLLECT = 1, M_DONE = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int                  m_st   [NUM_WARPS];
  int                  m_need [NUM_WARPS];
  int                  m_got  [NUM_WARPS];
  logic [ARCH_LEN-1:0] m_pc   [NUM_WARPS];
  trace_reg_t          m_regs [NUM_WARPS][MAX_TRACE_REGS];
  trace_rec_t          m_fifo [$];
  int                  m_ptr;
  bit                  m_err;

  always #5 clock = ~clock;

  cyclotron_trace_collector_if bus ();
  cyclotron_trace_collector dut (.clock(clock), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [DATA_BITS-1:0] obs, input logic [DATA_BITS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_BITS-1:0] rand_data();
    logic [DATA_BITS-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_LANES; i++) d[i*ARCH_LEN +: ARCH_LEN] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NUM_WARPS; w++) begin
      m_st[w] = M_IDLE; m_need[w] = 0; m_got[w] = 0; m_pc[w] = '0;
      for (int i = 0; i < MAX_TRACE_REGS; i++) m_regs[w][i] = '0;
    end
    m_fifo.delete();
    m_ptr = 0;
    m_err = 1'b0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit pop; int win; int w; trace_rec_t rec;
    pop = (m_fifo.size() != 0) && (bus.trace_ready === 1'b1);
    win = -1;
    for (int k = 0; k < NUM_WARPS; k++) begin
      w = (m_ptr + k) % NUM_WARPS;
      if (win < 0 && m_st[w] == M_DONE) win = w;
    end
    if (!(m_fifo.size() < FIFO_DEPTH || pop)) win = -1;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_valid[p]) begin
        w = int'(bus.wb_warpId[p]);
        if (m_st[w] == M_COLLECT && m_got[w] < m_need[w]) begin
          m_regs[w][m_got[w]].enable  = 1'b1;
          m_regs[w][m_got[w]].address = bus.wb_address[p];
          m_regs[w][m_got[w]].data    = bus.wb_data[p];
          m_got[w]++;
          if (m_got[w] == m_need[w]) m_st[w] = M_DONE;
        end else m_err = 1'b1;
      end
    end
    if (bus.commit_valid) begin
      w = int'(bus.commit_warpId);
      if (m_st[w] == M_IDLE) begin
        m_pc[w] = bus.commit_pc; m_need[w] = int'(bus.commit_numRegs); m_got[w] = 0;
        for (int i = 0; i < MAX_TRACE_REGS; i++) m_regs[w][i] = '0;
        m_st[w] = (m_need[w] == 0) ? M_DONE : M_COLLECT;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (win >= 0) begin
      rec = '0;
      rec.pc = m_pc[win];
      rec.warpId = WARP_ID_BITS'(win);
      for (int i = 0; i < MAX_TRACE_REGS; i++) rec.regs[i] = m_regs[win][i];
      m_fifo.push_back(rec);
      m_st[win] = M_IDLE;
      m_ptr = (win + 1) % NUM_WARPS;
    end
  endtask

  task automatic check_outputs();
    trace_rec_t e;
    chk("trace_valid", bus.trace_valid, m_fifo.size() != 0);
    chk("error", bus.error, m_err);
    chk("commit_ready", bus.commit_ready, m_st[bus.commit_warpId] == M_IDLE);
    if (m_fifo.size() != 0) begin
      e = m_fifo[0];
      chk("head_pc", bus.trace_pc, e.pc);
      chk("head_warp", bus.trace_warpId, e.warpId);
      chk("head_r0_en", bus.trace_regs_0_enable, e.regs[0].enable);
      chk("head_r0_addr", bus.trace_regs_0_address, e.regs[0].address);
      chk("head_r0_data", bus.trace_regs_0_data, e.regs[0].data);
      chk("head_r1_en", bus.trace_regs_1_enable, e.regs[1].enable);
      chk("head_r1_addr", bus.trace_regs_1_address, e.regs[1].address);
      chk("head_r1_data", bus.trace_regs_1_data, e.regs[1].data);
      chk("head_r2_en", bus.trace_regs_2_enable, e.regs[2].enable);
      chk("head_r2_addr", bus.trace_regs_2_address, e.regs[2].address);
      chk("head_r2_data", bus.trace_regs_2_data, e.regs[2].data);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic drive_idle();
    bus.commit_valid = 1'b0; bus.commit_pc = '0; bus.commit_warpId = '0; bus.commit_numRegs = '0;
    bus.wb_valid = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      bus.wb_warpId[p] = '0; bus.wb_address[p] = '0; bus.wb_data[p] = '0;
    end
  endtask

  task automatic set_commit(input int w, input logic [ARCH_LEN-1:0] pc, input int n);
    bus.commit_valid = 1'b1; bus.commit_warpId = WARP_ID_BITS'(w);
    bus.commit_pc = pc; bus.commit_numRegs = 2'(n);
  endtask

  task automatic set_wb(input int p, input int w, input int a, input logic [DATA_BITS-1:0] d);
    bus.wb_valid[p] = 1'b1; bus.wb_warpId[p] = WARP_ID_BITS'(w);
    bus.wb_address[p] = REG_BITS'(a); bus.wb_data[p] = d;
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", bus.trace_valid, 1'b0);
    chk("rst_error", bus.error, 1'b0);
    chk("rst_pc", bus.trace_pc, '0);
    chk("rst_warp", bus.trace_warpId, '0);
    chk("rst_en", {bus.trace_regs_0_enable, bus.trace_regs_1_enable, bus.trace_regs_2_enable}, '0);
    chk("rst_addr", {bus.trace_regs_0_address, bus.trace_regs_1_address, bus.trace_regs_2_address}, '0);
    chk("rst_data", bus.trace_regs_0_data | bus.trace_regs_1_data | bus.trace_regs_2_data, '0);
    for (int w = 0; w < NUM_WARPS; w++) begin
      bus.commit_warpId = WARP_ID_BITS'(w);
      #1;
      chk("rst_commit_ready", bus.commit_ready, 1'b1);
    end
  endtask

  initial begin
    logic [DATA_BITS-1:0] d1, d2;
    drive_idle();
    bus.trace_ready = 1'b1;
    model_reset();
    #3;
    check_reset_outputs();
    @(negedge clock);
    reset = 1'b1;

    // single record, two writebacks on consecutive cycles
    set_commit(3, 32'h8000_0100, 2); step();
    drive_idle(); set_wb(0, 3, 5, {NUM_LANES{32'hA}}); step();
    drive_idle(); set_wb(0, 3, 7, {NUM_LANES{32'h7}}); step();
    chk("t1_not_yet", bus.trace_valid, 1'b0);
    drive_idle(); bus.commit_warpId = 3; step();
    chk("t1_valid", bus.trace_valid, 1'b1);
    chk("t1_pc", bus.trace_pc, 32'h8000_0100);
    chk("t1_warp", bus.trace_warpId, 3);
    chk("t1_en", {bus.trace_regs_0_enable, bus.trace_regs_1_enable, bus.trace_regs_2_enable}, 3'b110);
    chk("t1_a0", bus.trace_regs_0_address, 5);
    chk("t1_a1", bus.trace_regs_1_address, 7);
    chk("t1_a2", bus.trace_regs_2_address, 0);
    chk("t1_d0", bus.trace_regs_0_data, {NUM_LANES{32'hA}});
    chk("t1_d2", bus.trace_regs_2_data, '0);
    chk("t1_ready3", bus.commit_ready, 1'b1);
    drive_idle(); step();

    // zero-reg commit
    set_commit(0, 32'h100, 0); step();
    drive_idle(); step();
    chk("t2_valid", bus.trace_valid, 1'b1);
    chk("t2_pc", bus.trace_pc, 32'h100);
    chk("t2_en", {bus.trace_regs_0_enable, bus.trace_regs_1_enable, bus.trace_regs_2_enable}, 3'b000);
    drive_idle(); step();

    // same-edge completions of warps 1 and 2
    set_commit(1, 32'h200, 1); step();
    set_commit(2, 32'h204, 1); step();
    drive_idle(); set_wb(0, 1, 10, rand_data()); set_wb(1, 2, 11, rand_data()); step();
    drive_idle(); step();
    chk("t3_tie1_first", bus.trace_warpId, 1);
    step();
    chk("t3_tie1_second", bus.trace_warpId, 2);
    step();
    set_commit(1, 32'h208, 0); step();
    drive_idle(); step(); step();
    set_commit(1, 32'h20C, 1); step();
    set_commit(2, 32'h210, 1); step();
    drive_idle(); set_wb(0, 1, 12, rand_data()); set_wb(1, 2, 13, rand_data()); step();
    drive_idle(); step();
    chk("t3_tie2_first", bus.trace_warpId, 2);
    step();
    chk("t3_tie2_second", bus.trace_warpId, 1);
    step();

    // backpressure: six completions, four buffered
    bus.trace_ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      set_commit(w, 32'h300 + 32'(4*w), 0); step();
    end
    drive_idle(); step(); step();
    set_commit(4, 32'h3F0, 1); step();
    chk("t4_stall4", bus.commit_ready, 1'b0);
    bus.commit_warpId = 5; #1;
    chk("t4_stall5", bus.commit_ready, 1'b0);
    drive_idle();
    bus.trace_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t4_order_valid", bus.trace_valid, 1'b1);
      chk("t4_order", bus.trace_warpId, k);
      step();
    end
    chk("t4_empty", bus.trace_valid, 1'b0);

    // both ports hit the same warp in one cycle
    d1 = rand_data(); d2 = rand_data();
    set_commit(6, 32'h400, 2); step();
    drive_idle(); set_wb(0, 6, 1, d1); set_wb(1, 6, 2, d2); step();
    drive_idle(); step();
    chk("t5_a0", bus.trace_regs_0_address, 1);
    chk("t5_a1", bus.trace_regs_1_address, 2);
    chk("t5_d0", bus.trace_regs_0_data, d1);
    chk("t5_d1", bus.trace_regs_1_data, d2);
    chk("t5_en2", bus.trace_regs_2_enable, 1'b0);
    step();

    // random traffic with legal writebacks, then a greedy completion tail
    for (int c = 0; c < 640; c++) begin
      int pend [NUM_WARPS];
      int w;
      bit used;
      bit tail;
      tail = (c >= 600);
      drive_idle();
      bus.trace_ready = tail ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NUM_WARPS; k++) pend[k] = 0;
      if (!tail && $urandom_range(0, 2) == 0)
        set_commit($urandom_range(0, NUM_WARPS-1), $urandom, $urandom_range(0, 3));
      for (int p = 0; p < WB_PORTS; p++) begin
        used = 1'b0;
        if (tail) begin
          for (int k = 0; k < NUM_WARPS; k++) begin
            if (!used && m_st[k] == M_COLLECT && m_got[k] + pend[k] < m_need[k]) begin
              set_wb(p, k, $urandom_range(0, 255), rand_data()); pend[k]++; used = 1'b1;
            end
          end
        end else if ($urandom_range(0, 1) == 1) begin
          w = $urandom_range(0, NUM_WARPS-1);
          if (m_st[w] == M_COLLECT && m_got[w] + pend[w] < m_need[w]) begin
            set_wb(p, w, $urandom_range(0, 255), rand_data()); pend[w]++;
          end
        end
      end
      step();
    end
    chk("rand_drained", bus.trace_valid, 1'b0);

    // writeback to an idle warp
    drive_idle(); set_wb(0, 4, 3, rand_data()); step();
    chk("err_set", bus.error, 1'b1);
    drive_idle(); step(); step(); step();
    chk("err_sticky", bus.error, 1'b1);
    chk("err_no_record", bus.trace_valid, 1'b0);

    // asynchronous reset in the middle of a collect
    set_commit(5, 32'h500, 3); step();
    drive_idle(); set_wb(0, 5, 1, rand_data()); step();
    drive_idle();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clock);
    reset = 1'b1;
    set_commit(5, 32'h600, 0); step();
    drive_idle(); step();
    chk("post_rst_valid", bus.trace_valid, 1'b1);
    chk("post_rst_pc", bus.trace_pc, 32'h600);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
